mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// Memory pipeline stage controller: accepts EX/MEM instructions, issues the
// data-memory access, extends load data and hands results to the MEM/WB latch.
//
// state  | meaning
// IDLE   | empty, ready for a new instruction
// ACCESS | data-memory request outstanding, waiting for dhit
// FULL   | result held for the downstream latch
// HALTED | halt consumed, stage frozen until reset
module mem_stage_ctrl #(
    parameter int STALL_CNT_W = 16
) (
    input  logic                   CLK,
    input  logic                   nRST,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   dREN_i,
    input  logic                   dWEN_i,
    input  logic [31:0]            addr_i,
    input  logic [31:0]            store_i,
    input  logic [2:0]             func3_i,
    input  logic [4:0]             rd_i,
    input  logic                   regWr_i,
    input  logic                   halt_i,
    input  logic [31:0]            npc_i,
    input  logic                   flush,
    input  logic                   dhit,
    input  logic [31:0]            dmemload,
    output logic                   dmemREN,
    output logic                   dmemWEN,
    output logic [31:0]            dmemaddr,
    output logic [31:0]            dmemstore,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            dmemload_o,
    output logic [4:0]             rd_o,
    output logic                   regWr_o,
    output logic                   halt_o,
    output logic [31:0]            npc_o,
    output logic                   halted,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, FULL, HALTED} state_t;

    state_t      state, next_state;
    logic        accept;
    logic        ren_q, wen_q, kill_q;
    logic [31:0] addr_q, store_q;
    logic [2:0]  func3_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        dmemREN    = 1'b0;
        dmemWEN    = 1'b0;
        dmemaddr   = '0;
        dmemstore  = '0;
        in_ready   = (state == IDLE) || (state == FULL && out_ready);
        // a consumed halt wins over any instruction offered in the same cycle
        accept     = in_valid && in_ready && !flush && !(state == FULL && halt_o);
        out_valid  = (state == FULL);
        halted     = (state == HALTED);
        case (state)
            IDLE: begin
                if (accept) next_state = (dREN_i || dWEN_i) ? ACCESS : FULL;
            end
            ACCESS: begin
                dmemREN   = ren_q;
                dmemWEN   = wen_q;
                dmemaddr  = addr_q;
                dmemstore = store_q;
                if (dhit) next_state = (kill_q || flush) ? IDLE : FULL;
            end
            FULL: begin
                if (flush)             next_state = IDLE;
                else if (out_ready) begin
                    if (halt_o)        next_state = HALTED;
                    else if (accept)   next_state = (dREN_i || dWEN_i) ? ACCESS : FULL;
                    else               next_state = IDLE;
                end
            end
            HALTED: next_state = HALTED;
        endcase
    end

    always_comb begin
        ld_byte = dmemload[7:0];
        case (addr_q[1:0])
            2'd0: ld_byte = dmemload[7:0];
            2'd1: ld_byte = dmemload[15:8];
            2'd2: ld_byte = dmemload[23:16];
            2'd3: ld_byte = dmemload[31:24];
        endcase
        ld_half = addr_q[1] ? dmemload[31:16] : dmemload[15:0];
        case (func3_q)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = dmemload;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ren_q      <= 1'b0;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            store_q    <= '0;
            func3_q    <= '0;
            rd_o       <= '0;
            regWr_o    <= 1'b0;
            halt_o     <= 1'b0;
            npc_o      <= '0;
            dmemload_o <= '0;
            kill_q     <= 1'b0;
            stall_cnt  <= '0;
        end else begin
            if (accept) begin
                ren_q      <= dREN_i;
                wen_q      <= dWEN_i && !dREN_i;
                addr_q     <= addr_i;
                store_q    <= store_i;
                func3_q    <= func3_i;
                rd_o       <= rd_i;
                regWr_o    <= regWr_i;
                halt_o     <= halt_i;
                npc_o      <= npc_i;
                dmemload_o <= '0;
            end else if (state == ACCESS && dhit) begin
                dmemload_o <= ren_q ? ld_ext : '0;
            end
            // kill survives only while the flushed access is still outstanding
            kill_q <= (state == ACCESS) && !dhit && (kill_q || flush);
            if (state == ACCESS && !dhit && !(&stall_cnt))
                stall_cnt <= stall_cnt + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: scoreboard of expected downstream results, one task
// per scenario, all stimulus driven on the falling clock edge.
module tb_mem_stage_ctrl;
    localparam int W = 16;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic          in_valid, in_ready, dREN_i, dWEN_i, regWr_i, halt_i, flush;
    logic [31:0]   addr_i, store_i, npc_i, dmemload, dmemaddr, dmemstore;
    logic [2:0]    func3_i;
    logic [4:0]    rd_i, rd_o;
    logic          dhit, dmemREN, dmemWEN, out_valid, out_ready;
    logic [31:0]   dmemload_o, npc_o;
    logic          regWr_o, halt_o, halted;
    logic [W-1:0]  stall_cnt;
    logic [70:0]   obs;
    logic [70:0]   sb[$];
    logic [70:0]   e;
    int            n_pass = 0;
    int            n_total = 0;
    int            exp_stall = 0;

    mem_stage_ctrl #(.STALL_CNT_W(W)) dut (
        .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
        .dREN_i(dREN_i), .dWEN_i(dWEN_i), .addr_i(addr_i), .store_i(store_i),
        .func3_i(func3_i), .rd_i(rd_i), .regWr_i(regWr_i), .halt_i(halt_i),
        .npc_i(npc_i), .flush(flush), .dhit(dhit), .dmemload(dmemload),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
        .dmemstore(dmemstore), .out_valid(out_valid), .out_ready(out_ready),
        .dmemload_o(dmemload_o), .rd_o(rd_o), .regWr_o(regWr_o), .halt_o(halt_o),
        .npc_o(npc_o), .halted(halted), .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;
    assign obs = {dmemload_o, rd_o, regWr_o, halt_o, npc_o};

    function automatic logic [31:0] ext_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] d, input logic is_load);
        logic [31:0] sh;
        if (!is_load) return 32'h0;
        case (f3)
            3'b000: begin sh = d >> (8 * a[1:0]); return {{24{sh[7]}}, sh[7:0]}; end
            3'b001: begin sh = d >> (a[1] ? 16 : 0); return {{16{sh[15]}}, sh[15:0]}; end
            3'b100: begin sh = d >> (8 * a[1:0]); return {24'h0, sh[7:0]}; end
            3'b101: begin sh = d >> (a[1] ? 16 : 0); return {16'h0, sh[15:0]}; end
            default: return d;
        endcase
    endfunction

    task automatic clear_in();
        in_valid = 0; dREN_i = 0; dWEN_i = 0; halt_i = 0; regWr_i = 0;
        addr_i = 0; store_i = 0; func3_i = 0; rd_i = 0; npc_i = 0;
    endtask

    task automatic drive_instr(input logic ren, input logic wen, input logic [31:0] addr,
                               input logic [31:0] st, input logic [2:0] f3, input logic [4:0] rd,
                               input logic rw, input logic hlt, input logic [31:0] npc,
                               input logic [31:0] mdata, input logic push);
        in_valid = 1; dREN_i = ren; dWEN_i = wen; addr_i = addr; store_i = st;
        func3_i = f3; rd_i = rd; regWr_i = rw; halt_i = hlt; npc_i = npc;
        if (push) sb.push_back({ext_model(f3, addr, mdata, ren), rd, rw, hlt, npc});
    endtask

    task automatic test_reset();
        #2;
        n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
        n_total++; if (halted !== 1'b0) $display("FAIL reset_halted got %b want 0", halted); else n_pass++;
        n_total++; if ({dmemREN, dmemWEN} !== 2'b00) $display("FAIL reset_dmem_req got %b want 00", {dmemREN, dmemWEN}); else n_pass++;
        n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
        n_total++; if (stall_cnt !== '0) $display("FAIL reset_stall_cnt got %0d want 0", stall_cnt); else n_pass++;
        @(negedge CLK); nRST = 1;
    endtask

    task automatic test_lb();
        @(negedge CLK);
        drive_instr(1, 0, 32'h103, 32'h0, 3'b000, 5'd4, 1, 0, 32'h0000_0010, 32'h80FF_1234, 1);
        n_total++; if (in_ready !== 1'b1) $display("FAIL lb_in_ready got %b want 1", in_ready); else n_pass++;
        for (int c = 1; c <= 4; c++) begin
            @(negedge CLK);
            clear_in();
            if (c < 4) begin
                n_total++; if ({dmemREN, dmemWEN, dmemaddr, out_valid} !== {2'b10, 32'h103, 1'b0})
                    $display("FAIL lb_access c%0d got ren=%b wen=%b addr=%h ov=%b want 1 0 103 0", c, dmemREN, dmemWEN, dmemaddr, out_valid);
                else n_pass++;
                dhit = (c == 3);
                dmemload = (c == 3) ? 32'h80FF_1234 : 32'h0;
                if (c < 3) exp_stall++;
            end else begin
                dhit = 0;
                n_total++; if (out_valid !== 1'b1) $display("FAIL lb_latency out_valid got %b want 1", out_valid); else n_pass++;
                e = sb.pop_front();
                n_total++; if (obs !== e) $display("FAIL lb_result got %h want %h", obs, e); else n_pass++;
                n_total++; if (dmemload_o !== 32'hFFFF_FF80) $display("FAIL lb_data got %h want ffffff80", dmemload_o); else n_pass++;
                n_total++; if (stall_cnt !== W'(exp_stall)) $display("FAIL lb_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
            end
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3[7]   = '{3'b101, 3'b001, 3'b100, 3'b010, 3'b011, 3'b010, 3'b000};
        logic [31:0] ad[7]   = '{32'h102, 32'h103, 32'h102, 32'h100, 32'h101, 32'h200, 32'h100};
        logic [31:0] md[7]   = '{32'hBEEF_0001, 32'h8001_1234, 32'h00AB_0000, 32'hDEAD_BEEF,
                                 32'h1234_5678, 32'h5555_5555, 32'h0000_007F};
        logic        rn[7]   = '{1, 1, 1, 1, 1, 0, 1};
        logic        wn[7]   = '{0, 0, 0, 0, 0, 1, 1};
        for (int i = 0; i < 7; i++) begin
            @(negedge CLK);
            drive_instr(rn[i], wn[i], ad[i], 32'hCAFE_F000 + i, f3[i], 5'(i + 1), 1, 0, 32'h100 + 4 * i, md[i], 1);
            @(negedge CLK);
            clear_in();
            n_total++; if ({dmemREN, dmemWEN, dmemaddr} !== {rn[i], wn[i] & ~rn[i], ad[i]})
                $display("FAIL mem_req[%0d] got ren=%b wen=%b addr=%h want %b %b %h", i, dmemREN, dmemWEN, dmemaddr, rn[i], wn[i] & ~rn[i], ad[i]);
            else n_pass++;
            if (wn[i] && !rn[i]) begin
                n_total++; if (dmemstore !== 32'hCAFE_F000 + i) $display("FAIL store_data[%0d] got %h want %h", i, dmemstore, 32'hCAFE_F000 + i); else n_pass++;
            end
            dhit = 1; dmemload = md[i];
            @(negedge CLK);
            dhit = 0; dmemload = 0;
            n_total++; if (out_valid !== 1'b1) $display("FAIL load_latency[%0d] out_valid got %b want 1", i, out_valid); else n_pass++;
            e = sb.pop_front();
            n_total++; if (obs !== e) $display("FAIL load_result[%0d] got %h want %h", i, obs, e); else n_pass++;
        end
        n_total++; if (32'h0000_BEEF !== ext_model(3'b101, 32'h102, 32'hBEEF_0001, 1'b1) || stall_cnt !== W'(exp_stall))
            $display("FAIL lhu_stall got %0d want %0d", stall_cnt, exp_stall);
        else n_pass++;
    endtask

    task automatic test_back_pressure();
        @(negedge CLK);
        out_ready = 0;
        drive_instr(0, 0, 32'h0, 32'h0, 3'b000, 5'd7, 1, 0, 32'h0000_1000, 32'h0, 1);
        @(negedge CLK);
        clear_in();
        n_total++; if (out_valid !== 1'b1) $display("FAIL nonmem_latency out_valid got %b want 1", out_valid); else n_pass++;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge CLK);
            n_total++; if ({out_valid, in_ready, obs} !== {2'b10, sb[0]})
                $display("FAIL bp_hold c%0d got ov=%b ir=%b %h want 1 0 %h", c, out_valid, in_ready, obs, sb[0]);
            else n_pass++;
            drive_instr(0, 0, 32'h0, 32'h0, 3'b000, 5'd9, 0, 0, 32'h0000_2000, 32'h0, 0);
        end
        @(negedge CLK);
        out_ready = 1;
        #1;
        n_total++; if (in_ready !== 1'b1) $display("FAIL bp_release in_ready got %b want 1", in_ready); else n_pass++;
        e = sb.pop_front();
        n_total++; if ({out_valid, obs} !== {1'b1, e}) $display("FAIL bp_first got ov=%b %h want 1 %h", out_valid, obs, e); else n_pass++;
        sb.push_back({32'h0, 5'd9, 1'b0, 1'b0, 32'h0000_2000});
        @(negedge CLK);
        clear_in();
        e = sb.pop_front();
        n_total++; if ({out_valid, obs} !== {1'b1, e}) $display("FAIL bp_no_bubble got ov=%b %h want 1 %h", out_valid, obs, e); else n_pass++;
        @(negedge CLK);
        n_total++; if (out_valid !== 1'b0) $display("FAIL bp_drain out_valid got %b want 0", out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        @(negedge CLK);
        drive_instr(0, 1, 32'h300, 32'h1111_2222, 3'b010, 5'd0, 0, 0, 32'h0000_3000, 32'h0, 0);
        for (int c = 1; c <= 5; c++) begin
            @(negedge CLK);
            clear_in();
            flush = (c == 1);
            if (c <= 3) begin
                n_total++; if ({dmemWEN, dmemREN, dmemaddr, dmemstore, out_valid} !== {2'b10, 32'h300, 32'h1111_2222, 1'b0})
                    $display("FAIL flush_store c%0d got wen=%b ren=%b addr=%h st=%h ov=%b", c, dmemWEN, dmemREN, dmemaddr, dmemstore, out_valid);
                else n_pass++;
                dhit = (c == 3);
                if (c < 3) exp_stall++;
            end else begin
                dhit = 0;
                n_total++; if ({out_valid, dmemWEN, in_ready} !== 3'b001)
                    $display("FAIL flush_idle c%0d got ov=%b wen=%b ir=%b want 0 0 1", c, out_valid, dmemWEN, in_ready);
                else n_pass++;
            end
        end
        n_total++; if (stall_cnt !== W'(exp_stall)) $display("FAIL flush_stall_cnt got %0d want %0d", stall_cnt, exp_stall); else n_pass++;
        out_ready = 0;
        drive_instr(0, 0, 32'h0, 32'h0, 3'b000, 5'd5, 1, 0, 32'h0000_4000, 32'h0, 0);
        @(negedge CLK);
        clear_in();
        n_total++; if (out_valid !== 1'b1) $display("FAIL flush_full_pre out_valid got %b want 1", out_valid); else n_pass++;
        flush = 1;
        @(negedge CLK);
        flush = 0; out_ready = 1;
        n_total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL flush_full got ov=%b ir=%b want 0 1", out_valid, in_ready); else n_pass++;
        drive_instr(1, 0, 32'h10, 32'h0, 3'b010, 5'd6, 1, 0, 32'h0000_5000, 32'h0, 0);
        flush = 1;
        @(negedge CLK);
        clear_in(); flush = 0;
        n_total++; if ({out_valid, dmemREN, in_ready} !== 3'b001)
            $display("FAIL flush_idle_accept got ov=%b ren=%b ir=%b want 0 0 1", out_valid, dmemREN, in_ready);
        else n_pass++;
    endtask

    task automatic test_reset_mid_access();
        @(negedge CLK);
        drive_instr(1, 0, 32'h104, 32'h0, 3'b010, 5'd3, 1, 0, 32'h0000_0044, 32'h0, 0);
        @(negedge CLK);
        clear_in();
        n_total++; if (dmemREN !== 1'b1) $display("FAIL rst_pre_ren got %b want 1", dmemREN); else n_pass++;
        #2 nRST = 0;
        #1;
        n_total++; if ({dmemREN, dmemWEN, dmemaddr, out_valid, in_ready} !== {2'b00, 32'h0, 2'b01})
            $display("FAIL rst_mid_req got ren=%b wen=%b addr=%h ov=%b ir=%b", dmemREN, dmemWEN, dmemaddr, out_valid, in_ready);
        else n_pass++;
        n_total++; if ({obs, stall_cnt} !== '0) $display("FAIL rst_mid_regs got %h stall=%0d want 0", obs, stall_cnt); else n_pass++;
        exp_stall = 0;
        @(negedge CLK); nRST = 1;
        dhit = 1; dmemload = 32'hFFFF_FFFF;
        @(negedge CLK); dhit = 0;
        n_total++; if ({out_valid, dmemload_o} !== 33'h0) $display("FAIL rst_no_result got ov=%b d=%h want 0", out_valid, dmemload_o); else n_pass++;
    endtask

    task automatic test_halt();
        @(negedge CLK);
        drive_instr(0, 0, 32'h0, 32'h0, 3'b000, 5'd0, 0, 1, 32'h0000_0088, 32'h0, 1);
        @(negedge CLK);
        clear_in();
        e = sb.pop_front();
        n_total++; if ({out_valid, obs} !== {1'b1, e}) $display("FAIL halt_result got ov=%b %h want 1 %h", out_valid, obs, e); else n_pass++;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            n_total++; if ({halted, in_ready, out_valid} !== 3'b100)
                $display("FAIL halted c%0d got h=%b ir=%b ov=%b want 1 0 0", c, halted, in_ready, out_valid);
            else n_pass++;
            drive_instr(1, 0, 32'h20, 32'h0, 3'b010, 5'd8, 1, 0, 32'h0000_6000, 32'h0, 0);
        end
        clear_in();
    endtask

    initial begin
        clear_in();
        flush = 0; dhit = 0; dmemload = 0; out_ready = 1;
        test_reset();
        test_lb();
        test_loads();
        test_back_pressure();
        test_flush();
        test_reset_mid_access();
        test_halt();
        n_total++; if (sb.size() != 0) $display("FAIL scoreboard_left got %0d want 0", sb.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
